// File: rtl/seq_detect_pkg.sv
// Shared types for the multi-channel "1010" detector: detector state encoding
// and the channel-index width helper.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    // A one-bit index is kept even when only one channel would exist.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_detect_core.sv
// Combinational next-state/output logic of an overlapping "1010" Mealy detector.
// Shared by all channels; the caller muxes in the granted channel's state.
module seq_detect_core
    import seq_detect_pkg::*;
(
    input  logic       x,
    input  logic [1:0] ps,
    output logic [1:0] ns,
    output logic       z
);

    always_comb begin
        ns = S0;
        z  = 1'b0;
        case (state_t'(ps))
            S0: ns = x ? S1 : S0;
            S1: ns = x ? S1 : S2;
            S2: ns = x ? S3 : S0;
            S3: begin
                ns = x ? S1 : S2;
                z  = ~x;
            end
            default: ns = S0;
        endcase
    end

endmodule

// File: rtl/seq_detect_arbiter.sv
// Round-robin time-shares one "1010" detector core among NCH serial channels,
// keeping a stored detector state per channel and a registered match report.
module seq_detect_arbiter
    import seq_detect_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int CW  = ch_width(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   req,
    input  logic [NCH-1:0]   bit_in,
    input  logic [NCH-1:0]   clear,
    output logic [NCH-1:0]   gnt,
    output logic             match_valid,
    output logic [CW-1:0]    match_ch,
    output logic [2*NCH-1:0] state_o
);

    state_t         state_reg  [NCH];
    state_t         state_next [NCH];
    logic [CW-1:0]  ptr_reg;
    logic           match_valid_reg;
    logic [CW-1:0]  match_ch_reg;

    logic [NCH-1:0] elig;
    logic [CW-1:0]  cand;
    logic [CW-1:0]  gnt_idx;
    logic           gnt_any;
    logic [1:0]     core_ps;
    logic [1:0]     core_ns;
    logic           core_z;

    // A channel being cleared must not consume its bit this cycle.
    assign elig = req & ~clear;

    // Scan from ptr+1 around the ring; the first eligible channel wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = CW'((int'(ptr_reg) + k) % NCH);
            if (!gnt_any && elig[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign core_ps = state_reg[gnt_idx];

    seq_detect_core u_core (
        .x  (bit_in[gnt_idx]),
        .ps (core_ps),
        .ns (core_ns),
        .z  (core_z)
    );

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        assign state_next[gi] = clear[gi] ? S0 :
                                gnt[gi]   ? state_t'(core_ns) :
                                            state_reg[gi];
        assign state_o[2*gi +: 2] = state_reg[gi];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                state_reg[i] <= S0;
            end
        end else begin
            state_reg <= state_next;
        end
    end

    // ptr resets to the last channel so channel 0 is searched first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg         <= CW'(NCH - 1);
            match_valid_reg <= 1'b0;
            match_ch_reg    <= '0;
        end else if (gnt_any) begin
            ptr_reg         <= gnt_idx;
            match_valid_reg <= core_z;
            match_ch_reg    <= gnt_idx;
        end else begin
            match_valid_reg <= 1'b0;
        end
    end

    assign match_valid = match_valid_reg;
    assign match_ch    = match_ch_reg;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Directed table-driven bench for seq_detect_arbiter with NCH=4.
`timescale 1ns/1ps
module tb_seq_detect_arbiter;

    localparam int NCH = 4;
    localparam int CW  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   bit_in;
    logic [NCH-1:0]   clear;
    logic [NCH-1:0]   gnt;
    logic             match_valid;
    logic [CW-1:0]    match_ch;
    logic [2*NCH-1:0] state_o;

    int checks = 0;
    int passes = 0;

    seq_detect_arbiter #(.NCH(NCH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .bit_in      (bit_in),
        .clear       (clear),
        .gnt         (gnt),
        .match_valid (match_valid),
        .match_ch    (match_ch),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;   // pulse reset before applying this row
        logic [3:0] req;
        logic [3:0] bits;
        logic [3:0] clr;
        logic [3:0] gnt;
        logic       mv;
        logic [1:0] mc;
        logic [7:0] st;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] rq, input logic [3:0] bt,
                                input logic [3:0] cl, input logic [3:0] g, input logic mv,
                                input logic [1:0] mc, input logic [7:0] st);
        vec_t v;
        v.rst = rst; v.req = rq; v.bits = bt; v.clr = cl;
        v.gnt = g; v.mv = mv; v.mc = mc; v.st = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passes++;
    endtask

    task automatic do_reset();
        req = '0; bit_in = '0; clear = '0;
        reset = 1'b1;
        #3;
        reset = 1'b0;
    endtask

    // Entered shortly after a rising edge; returns 1ns after the next one.
    task automatic apply(input vec_t v, input string tag);
        if (v.rst) do_reset();
        req = v.req; bit_in = v.bits; clear = v.clr;
        #1;
        chk({tag, " gnt"}, {4'b0, gnt}, {4'b0, v.gnt});
        @(posedge clk);
        #1;
        chk({tag, " match_valid"}, {7'b0, match_valid}, {7'b0, v.mv});
        if (v.mv) chk({tag, " match_ch"}, {6'b0, match_ch}, {6'b0, v.mc});
        chk({tag, " state_o"}, state_o, v.st);
        $display("%s: req=%b bit=%b clr=%b gnt=%b mv=%b mc=%0d st=%h",
                 tag, v.req, v.bits, v.clr, gnt, match_valid, match_ch, state_o);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tab.size(); i++)
            apply(tab[i], $sformatf("%s[%0d]", tag, i));
        tab.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req = 4'b0101; bit_in = '0; clear = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset state_o", state_o, 8'h00);
        chk("reset match_valid", {7'b0, match_valid}, 8'h00);
        chk("reset match_ch", {6'b0, match_ch}, 8'h00);
        chk("gnt during reset", {4'b0, gnt}, 8'h01);
        reset = 1'b0; req = '0;

        // Single channel 1,0,1,0,1,0 then idle, then pointer-hold check
        tab.push_back(mk(0, 4'b0001, 4'b0001, 4'b0, 4'b0001, 0, 0, 8'h01));
        tab.push_back(mk(0, 4'b0001, 4'b0000, 4'b0, 4'b0001, 0, 0, 8'h02));
        tab.push_back(mk(0, 4'b0001, 4'b0001, 4'b0, 4'b0001, 0, 0, 8'h03));
        tab.push_back(mk(0, 4'b0001, 4'b0000, 4'b0, 4'b0001, 1, 0, 8'h02));
        tab.push_back(mk(0, 4'b0001, 4'b0001, 4'b0, 4'b0001, 0, 0, 8'h03));
        tab.push_back(mk(0, 4'b0001, 4'b0000, 4'b0, 4'b0001, 1, 0, 8'h02));
        for (int i = 0; i < 5; i++)
            tab.push_back(mk(0, 4'b0000, 4'b0000, 4'b0, 4'b0000, 0, 0, 8'h02));
        tab.push_back(mk(0, 4'b0011, 4'b0000, 4'b0, 4'b0010, 0, 0, 8'h02));
        tab.push_back(mk(0, 4'b0001, 4'b0000, 4'b0, 4'b0001, 0, 0, 8'h00));
        run_table("single");

        // Fairness: all four request; ch2 alone sees 1,0,1,0
        tab.push_back(mk(1, 4'b1111, 4'b1111, 4'b0, 4'b0001, 0, 0, 8'h01));
        tab.push_back(mk(0, 4'b1111, 4'b1111, 4'b0, 4'b0010, 0, 0, 8'h05));
        tab.push_back(mk(0, 4'b1111, 4'b1111, 4'b0, 4'b0100, 0, 0, 8'h15));
        tab.push_back(mk(0, 4'b1111, 4'b1011, 4'b0, 4'b1000, 0, 0, 8'h55));
        tab.push_back(mk(0, 4'b1111, 4'b1011, 4'b0, 4'b0001, 0, 0, 8'h55));
        tab.push_back(mk(0, 4'b1111, 4'b1011, 4'b0, 4'b0010, 0, 0, 8'h55));
        tab.push_back(mk(0, 4'b1111, 4'b1011, 4'b0, 4'b0100, 0, 0, 8'h65));
        tab.push_back(mk(0, 4'b1111, 4'b1111, 4'b0, 4'b1000, 0, 0, 8'h65));
        tab.push_back(mk(0, 4'b1111, 4'b1111, 4'b0, 4'b0001, 0, 0, 8'h65));
        tab.push_back(mk(0, 4'b1111, 4'b1111, 4'b0, 4'b0010, 0, 0, 8'h65));
        tab.push_back(mk(0, 4'b1111, 4'b1111, 4'b0, 4'b0100, 0, 0, 8'h75));
        tab.push_back(mk(0, 4'b1111, 4'b1011, 4'b0, 4'b1000, 0, 0, 8'h75));
        tab.push_back(mk(0, 4'b1111, 4'b1011, 4'b0, 4'b0001, 0, 0, 8'h75));
        tab.push_back(mk(0, 4'b1111, 4'b1011, 4'b0, 4'b0010, 0, 0, 8'h75));
        tab.push_back(mk(0, 4'b1111, 4'b1011, 4'b0, 4'b0100, 1, 2, 8'h65));
        tab.push_back(mk(0, 4'b1111, 4'b1111, 4'b0, 4'b1000, 0, 0, 8'h65));
        run_table("fair");

        // Clear collides with the completing bit on ch1
        tab.push_back(mk(1, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 0, 0, 8'h04));
        tab.push_back(mk(0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 0, 0, 8'h08));
        tab.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 0, 0, 8'h0C));
        tab.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 0, 0, 8'h00));
        tab.push_back(mk(0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 0, 0, 8'h00));
        run_table("clear");

        // ch2 and ch3 build up, ch2 matches while ch3 sits in S3
        tab.push_back(mk(1, 4'b0100, 4'b0100, 4'b0, 4'b0100, 0, 0, 8'h10));
        tab.push_back(mk(0, 4'b0100, 4'b0000, 4'b0, 4'b0100, 0, 0, 8'h20));
        tab.push_back(mk(0, 4'b0100, 4'b0100, 4'b0, 4'b0100, 0, 0, 8'h30));
        tab.push_back(mk(0, 4'b1000, 4'b1000, 4'b0, 4'b1000, 0, 0, 8'h70));
        tab.push_back(mk(0, 4'b1000, 4'b0000, 4'b0, 4'b1000, 0, 0, 8'hB0));
        tab.push_back(mk(0, 4'b1000, 4'b1000, 4'b0, 4'b1000, 0, 0, 8'hF0));
        tab.push_back(mk(0, 4'b0100, 4'b0000, 4'b0, 4'b0100, 1, 2, 8'hE0));
        run_table("async");

        // Reset pulse strictly between edges must clear immediately
        req = '0; bit_in = '0;
        #3;
        reset = 1'b1;
        #1;
        chk("async reset state_o", state_o, 8'h00);
        chk("async reset match_valid", {7'b0, match_valid}, 8'h00);
        $display("async reset: st=%h mv=%b", state_o, match_valid);
        #1;
        reset = 1'b0;
        tab.push_back(mk(0, 4'b1000, 4'b0000, 4'b0, 4'b1000, 0, 0, 8'h00));
        run_table("post_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
